wb_master_initiator: RTL and testbench

- Wishbone classic single-transfer initiator: turns a valid/ready command stream into one Wishbone read or write cycle and returns a response on a valid/ready stream.
- Drives the slave-side port of the user project (cyc/stb/we/sel/adr/dat in, ack/dat out), so block-level benches and on-chip test logic can exercise the user project without the management SoC.
- One transaction outstanding at a time.
- Bus timeout aborts cycles from hung slaves.

---
 rtl/wb_master_initiator.sv | 160 ++++++++++++++++
 tb/tb_wb_master_initiator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_initiator.sv
// Wishbone classic single-transfer initiator.
// Converts a valid/ready command stream into one bus cycle plus a response.
module wb_master_initiator #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_we,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    output logic [7:0]          timeout_cnt_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t              state, state_n;
    logic                cyc_q, cyc_n;
    logic                we_q, we_n;
    logic [ADDR_W-1:0]   adr_q, adr_n;
    logic [DATA_W-1:0]   dat_q, dat_n;
    logic [SEL_W-1:0]    sel_q, sel_n;
    logic                rv_q, rv_n;
    logic [DATA_W-1:0]   rdat_q, rdat_n;
    logic                rwe_q, rwe_n;
    logic                rerr_q, rerr_n;
    logic [7:0]          tcnt_q, tcnt_n;
    logic [CNT_W-1:0]    wait_q, wait_n;
    logic                timed_out;

    // The final allowed stb cycle is the one where the wait count hits LAST_WAIT.
    assign timed_out = (TIMEOUT_CYCLES > 0) && (wait_q == LAST_WAIT);

    always_comb begin
        state_n = state;
        cyc_n   = cyc_q;
        we_n    = we_q;
        adr_n   = adr_q;
        dat_n   = dat_q;
        sel_n   = sel_q;
        rv_n    = rv_q;
        rdat_n  = rdat_q;
        rwe_n   = rwe_q;
        rerr_n  = rerr_q;
        tcnt_n  = tcnt_q;
        wait_n  = wait_q;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    we_n    = cmd_we;
                    adr_n   = cmd_adr;
                    dat_n   = cmd_dat;
                    sel_n   = cmd_sel;
                    cyc_n   = 1'b1;
                    wait_n  = '0;
                    state_n = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    cyc_n   = 1'b0;
                    rv_n    = 1'b1;
                    rerr_n  = 1'b0;
                    rwe_n   = we_q;
                    rdat_n  = we_q ? '0 : wbm_dat_i;
                    state_n = RESP;
                end else if (timed_out) begin
                    cyc_n   = 1'b0;
                    rv_n    = 1'b1;
                    rerr_n  = 1'b1;
                    rwe_n   = we_q;
                    rdat_n  = '0;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_n = tcnt_q + 8'd1;
                    end
                    state_n = RESP;
                end else begin
                    wait_n = wait_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rv_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state  <= IDLE;
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
            sel_q  <= '0;
            rv_q   <= 1'b0;
            rdat_q <= '0;
            rwe_q  <= 1'b0;
            rerr_q <= 1'b0;
            tcnt_q <= '0;
            wait_q <= '0;
        end else begin
            state  <= state_n;
            cyc_q  <= cyc_n;
            we_q   <= we_n;
            adr_q  <= adr_n;
            dat_q  <= dat_n;
            sel_q  <= sel_n;
            rv_q   <= rv_n;
            rdat_q <= rdat_n;
            rwe_q  <= rwe_n;
            rerr_q <= rerr_n;
            tcnt_q <= tcnt_n;
            wait_q <= wait_n;
        end
    end

    assign cmd_ready     = (state == IDLE);
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_we_o      = we_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = dat_q;
    assign wbm_sel_o     = sel_q;
    assign rsp_valid     = rv_q;
    assign rsp_dat       = rdat_q;
    assign rsp_we        = rwe_q;
    assign rsp_err       = rerr_q;
    assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_wb_master_initiator.sv
// Scoreboard bench for wb_master_initiator with a 4-cycle bus timeout.
// Stimulus queues expected responses; a negedge monitor pops and compares.
module tb_wb_master_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [7:0]  timeout_cnt_o;

    always #5 clk = ~clk;

    wb_master_initiator #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we(cmd_we),
        .cmd_adr(cmd_adr),
        .cmd_dat(cmd_dat),
        .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat),
        .rsp_we(rsp_we),
        .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i),
        .timeout_cnt_o(timeout_cnt_o)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_we", 32'(rsp_we), 32'(mon_e.we));
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                check("rsp_dat", rsp_dat, mon_e.dat);
            end
        end
    end

    task automatic wait_ready();
        int g;
        g = 0;
        while (!cmd_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic push_exp(input logic we, input logic [31:0] rdat,
                            input logic err);
        rsp_t r;
        r.we  = we;
        r.err = err;
        r.dat = (we || err) ? 32'h0 : rdat;
        exp_q.push_back(r);
    endtask

    task automatic run_bus(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int ack_at, input logic [31:0] rdat,
                           input int exp_n);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b1;
        while (wbm_cyc_o && n < 40) begin
            n++;
            if (!wbm_stb_o || wbm_we_o !== we || wbm_adr_o !== adr ||
                wbm_sel_o !== sel || (we && wbm_dat_o !== dat))
                ok = 1'b0;
            wbm_ack_i = (n == ack_at);
            wbm_dat_i = rdat;
            @(negedge clk);
            wbm_ack_i = 1'b0;
            wbm_dat_i = 32'hDEAD_BEEF;
        end
        check("stb_cycles", 32'(n), 32'(exp_n));
        check("bus_fields", 32'(ok), 32'd1);
        check("rsp_valid_next", 32'(rsp_valid), 32'd1);
        check("cyc_dropped", 32'(wbm_cyc_o), 32'd0);
    endtask

    task automatic do_txn(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input int ack_at, input logic [31:0] rdat,
                          input int exp_n, input logic exp_err);
        wait_ready();
        push_exp(we, rdat, exp_err);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
        run_bus(we, adr, dat, sel, ack_at, rdat, exp_n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b1;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_cyc", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_tcnt", 32'(timeout_cnt_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2,
               32'h1111_2222, 2, 1'b0);
        do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1,
               32'hCAFE_F00D, 1, 1'b0);
        do_txn(1'b0, 32'h3000_0014, 32'h0, 4'hF, 0,
               32'h5555_AAAA, 4, 1'b1);
        check("tcnt_one", 32'(timeout_cnt_o), 32'd1);
        do_txn(1'b0, 32'h3000_0018, 32'h0, 4'h5, 4,
               32'h0F0F_0F0F, 4, 1'b0);
        check("tcnt_boundary", 32'(timeout_cnt_o), 32'd1);

        @(negedge clk);
        ok = 1'b1;
        wbm_ack_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || wbm_cyc_o || !cmd_ready) ok = 1'b0;
        end
        wbm_ack_i = 1'b0;
        check("spurious_ack", 32'(ok), 32'd1);
        check("tcnt_spurious", 32'(timeout_cnt_o), 32'd1);

        rsp_ready = 1'b0;
        do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 2,
               32'h1234_5678, 2, 1'b0);
        push_exp(1'b1, 32'h0, 1'b0);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0030;
        cmd_dat   = 32'h0BAD_F00D;
        cmd_sel   = 4'h3;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (cmd_ready || !rsp_valid || rsp_dat !== 32'h1234_5678 ||
                rsp_err || rsp_we) ok = 1'b0;
        end
        check("bp_stable", 32'(ok), 32'd1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd1);
        check("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        run_bus(1'b1, 32'h3000_0030, 32'h0BAD_F00D, 4'h3, 1,
                32'h7777_7777, 1);

        for (int i = 0; i < 300; i++) begin
            do_txn(1'b0, 32'h4000_0000 + 32'(i * 4), 32'h0, 4'hF, 0,
                   32'h5A5A_0000, 4, 1'b1);
        end
        check("tcnt_saturate", 32'(timeout_cnt_o), 32'd255);

        wait_ready();
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0040;
        cmd_sel   = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_rst_cyc", 32'(wbm_cyc_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cyc", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        check("async_rst_rsp", 32'(rsp_valid), 32'd0);
        check("async_rst_tcnt", 32'(timeout_cnt_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        do_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 3,
               32'h8765_4321, 3, 1'b0);
        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
